// File: rtl/kill_go_pkg.sv
// Shared state encoding for the go/kill/done job initiator.
// Also holds the saturating increment used by the abort counter.
package kill_go_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_KILL   = 2'd3
  } kg_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/kg_cycle_timer.sv
// Loadable up-counter with a terminal flag.
// Stops at the terminal value instead of wrapping.
module kg_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic             term
);

  logic [WIDTH-1:0] count;

  assign term = (count == last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !term) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/kill_go_ctrl.sv
// Initiator for the go/kill/done job protocol: launch, time out,
// abort with kill, retry, then report ok or fail to the host.
module kill_go_ctrl
  import kill_go_pkg::*;
#(
  parameter int TIMEOUT   = 128,
  parameter int KILL_HOLD = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       req_ack,
  output logic       busy,
  output logic       go,
  output logic       kill,
  input  logic       done_in,
  output logic       ok,
  output logic       fail,
  output logic [1:0] attempt,
  output logic [7:0] timeouts,
  output logic       stray_done
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int HW = $clog2(KILL_HOLD + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] H_LAST = HW'(KILL_HOLD - 1);
  localparam logic [1:0]    A_LAST = 2'(MAX_RETRY);

  kg_state_e  state, state_n;
  logic       accept, to_kill, ok_n, fail_n;
  logic [1:0] att_n;
  logic       wait_term, hold_term;

  // Both timers restart whenever their state is entered.
  kg_cycle_timer #(.WIDTH(TW)) u_wait_tmr (
    .clk   (clk),
    .reset (reset),
    .load  (state != ST_WAIT),
    .en    (state == ST_WAIT),
    .last  (T_LAST),
    .term  (wait_term)
  );

  kg_cycle_timer #(.WIDTH(HW)) u_hold_tmr (
    .clk   (clk),
    .reset (reset),
    .load  (state != ST_KILL),
    .en    (state == ST_KILL),
    .last  (H_LAST),
    .term  (hold_term)
  );

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    to_kill = 1'b0;
    ok_n    = 1'b0;
    fail_n  = 1'b0;
    att_n   = attempt;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          att_n   = 2'd0;
          state_n = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_n = ST_WAIT;
      ST_WAIT: begin
        // done beats a coincident timeout
        if (done_in) begin
          ok_n    = 1'b1;
          state_n = ST_IDLE;
        end else if (wait_term) begin
          to_kill = 1'b1;
          state_n = ST_KILL;
        end
      end
      ST_KILL: begin
        if (hold_term) begin
          if (attempt == A_LAST) begin
            fail_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            att_n   = attempt + 2'd1;
            state_n = ST_LAUNCH;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_ack    <= 1'b0;
      busy       <= 1'b0;
      go         <= 1'b0;
      kill       <= 1'b0;
      ok         <= 1'b0;
      fail       <= 1'b0;
      attempt    <= 2'd0;
      timeouts   <= 8'd0;
      stray_done <= 1'b0;
    end else begin
      state   <= state_n;
      req_ack <= accept;
      busy    <= (state_n != ST_IDLE);
      go      <= (state_n == ST_LAUNCH);
      kill    <= (state_n == ST_KILL);
      ok      <= ok_n;
      fail    <= fail_n;
      attempt <= att_n;
      if (to_kill) begin
        timeouts <= sat_inc8(timeouts);
      end
      if (accept) begin
        stray_done <= 1'b0;
      end else if (done_in && state != ST_WAIT) begin
        stray_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kill_go_ctrl.sv
// Scoreboard bench for kill_go_ctrl with a behavioural worker.
// Expected events are queued by the stimulus and retired by a monitor.
module tb_kill_go_ctrl;

  localparam int TIMEOUT   = 128;
  localparam int KILL_HOLD = 4;
  localparam int MAX_RETRY = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       done_in = 1'b0;
  logic       req_ack, busy, go, kill, ok, fail, stray_done;
  logic [1:0] attempt;
  logic [7:0] timeouts;

  typedef enum int {K_ACK, K_GO, K_KILL, K_OK, K_FAIL} kind_e;
  typedef struct {
    kind_e kind;
    int    att;
    int    to;
    int    st;
  } ev_t;

  ev_t sbq[$];
  int  wq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  kill_go_ctrl #(
    .TIMEOUT   (TIMEOUT),
    .KILL_HOLD (KILL_HOLD),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_ack    (req_ack),
    .busy       (busy),
    .go         (go),
    .kill       (kill),
    .done_in    (done_in),
    .ok         (ok),
    .fail       (fail),
    .attempt    (attempt),
    .timeouts   (timeouts),
    .stray_done (stray_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input kind_e k, input int a,
                           input int t, input int s);
    ev_t e;
    e.kind = k;
    e.att  = a;
    e.to   = t;
    e.st   = s;
    sbq.push_back(e);
  endtask

  task automatic take(input kind_e k);
    ev_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", int'(k));
      return;
    end
    e = sbq.pop_front();
    chk("event_kind", int'(k), int'(e.kind));
    case (k)
      K_ACK: begin
        chk("ack_stray", int'(stray_done), e.st);
        chk("ack_busy", int'(busy), 1);
      end
      K_GO:   chk("go_attempt", int'(attempt), e.att);
      K_KILL: chk("kill_timeouts", int'(timeouts), e.to);
      K_OK: begin
        chk("ok_attempt", int'(attempt), e.att);
        chk("ok_timeouts", int'(timeouts), e.to);
        chk("ok_stray", int'(stray_done), e.st);
      end
      default: begin
        chk("fail_attempt", int'(attempt), e.att);
        chk("fail_timeouts", int'(timeouts), e.to);
      end
    endcase
  endtask

  // Monitor: retires scoreboard entries whenever the DUT signals
  initial begin
    int go_cyc;
    int kill_len;
    go_cyc   = -1;
    kill_len = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        go_cyc   = -1;
        kill_len = 0;
      end else begin
        if (go && kill) chk("go_kill_overlap", 1, 0);
        if (ok && fail) chk("ok_fail_overlap", 1, 0);
        if (req_ack) take(K_ACK);
        if (go) begin
          take(K_GO);
          go_cyc = cyc;
        end
        if (kill && kill_len == 0) begin
          take(K_KILL);
          chk("wait_len", cyc - go_cyc, TIMEOUT + 1);
        end
        if (kill) begin
          kill_len++;
        end else if (kill_len != 0) begin
          chk("kill_len", kill_len, KILL_HOLD);
          kill_len = 0;
        end
        if (ok) take(K_OK);
        if (fail) take(K_FAIL);
      end
    end
  end

  task automatic pulse_done(input int d);
    repeat (d) @(posedge clk);
    #1 done_in = 1'b1;
    @(posedge clk);
    #1 done_in = 1'b0;
  endtask

  // Worker: answers each go after the queued delay (-1 = never)
  initial begin
    forever begin : wk
      automatic int d;
      @(negedge clk);
      if (go && !reset) begin
        d = (wq.size() > 0) ? wq.pop_front() : -1;
        if (d >= 0) begin
          fork
            pulse_done(d);
          join_none
        end
      end
    end
  end

  task automatic job_start();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({req_ack, busy, go, kill, ok, fail,
                    attempt, timeouts, stray_done}), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_all_zero("reset_state");
    reset = 1'b0;

    // T1: single job, worker answers after 100 cycles
    wq.push_back(100);
    expect_ev(K_ACK, 0, 0, 0);
    expect_ev(K_GO, 0, 0, 0);
    expect_ev(K_OK, 0, 0, 0);
    job_start();
    wait_idle(1000);

    // T1b: req held high, two jobs back to back
    wq.push_back(5);
    wq.push_back(5);
    repeat (2) begin
      expect_ev(K_ACK, 0, 0, 0);
      expect_ev(K_GO, 0, 0, 0);
      expect_ev(K_OK, 0, 0, 0);
    end
    @(negedge clk);
    req = 1'b1;
    begin
      int n;
      n = 0;
      while (!ok && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_first_ok", int'(ok), 1);
      @(negedge clk);
      chk("b2b_ack_next", int'(req_ack), 1);
      req = 1'b0;
    end
    wait_idle(1000);

    // T3: silent on attempt 0, answers on attempt 1
    wq.push_back(-1);
    wq.push_back(60);
    expect_ev(K_ACK, 0, 0, 0);
    expect_ev(K_GO, 0, 0, 0);
    expect_ev(K_KILL, 0, 1, 0);
    expect_ev(K_GO, 1, 0, 0);
    expect_ev(K_OK, 1, 1, 0);
    job_start();
    wait_idle(1000);

    // T4: done on the exact timeout cycle wins
    wq.push_back(TIMEOUT);
    expect_ev(K_ACK, 0, 0, 0);
    expect_ev(K_GO, 0, 0, 0);
    expect_ev(K_OK, 0, 1, 0);
    job_start();
    wait_idle(1000);

    // T2: worker never answers
    repeat (3) wq.push_back(-1);
    expect_ev(K_ACK, 0, 0, 0);
    expect_ev(K_GO, 0, 0, 0);
    expect_ev(K_KILL, 0, 2, 0);
    expect_ev(K_GO, 1, 0, 0);
    expect_ev(K_KILL, 0, 3, 0);
    expect_ev(K_GO, 2, 0, 0);
    expect_ev(K_KILL, 0, 4, 0);
    expect_ev(K_FAIL, 2, 4, 0);
    job_start();
    wait_idle(1000);

    // T5: done during KILL, req during WAIT
    wq.push_back(TIMEOUT + 2);
    wq.push_back(50);
    expect_ev(K_ACK, 0, 0, 0);
    expect_ev(K_GO, 0, 0, 0);
    expect_ev(K_KILL, 0, 5, 0);
    expect_ev(K_GO, 1, 0, 0);
    expect_ev(K_OK, 1, 5, 1);
    job_start();
    repeat (20) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (140) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_idle(1000);
    chk("stray_sticky", int'(stray_done), 1);

    wq.push_back(10);
    expect_ev(K_ACK, 0, 0, 0);
    expect_ev(K_GO, 0, 0, 0);
    expect_ev(K_OK, 0, 5, 0);
    job_start();
    wait_idle(1000);

    // T6a: reset mid-WAIT
    wq.push_back(-1);
    expect_ev(K_ACK, 0, 0, 0);
    expect_ev(K_GO, 0, 0, 0);
    job_start();
    repeat (50) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("reset_mid_wait");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("sb_after_reset_wait", sbq.size(), 0);

    // T6b: reset mid-KILL
    wq.push_back(-1);
    expect_ev(K_ACK, 0, 0, 0);
    expect_ev(K_GO, 0, 0, 0);
    expect_ev(K_KILL, 0, 1, 0);
    job_start();
    begin
      int n;
      n = 0;
      while (!kill && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("kill_reached", int'(kill), 1);
    end
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("reset_mid_kill");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("sb_after_reset_kill", sbq.size(), 0);

    // Normal job after reset
    wq.push_back(20);
    expect_ev(K_ACK, 0, 0, 0);
    expect_ev(K_GO, 0, 0, 0);
    expect_ev(K_OK, 0, 0, 0);
    job_start();
    wait_idle(1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
